tl_sensor_gen: RTL and testbench

TL_SENSOR_GEN -- requirements
Module: tl_sensor_gen

---
 rtl/tl_sensor_gen_pkg.sv | 28 ++
 rtl/tl_lane_queue.sv | 77 +++++++
 rtl/tl_sensor_gen.sv | 56 +++++
 tb/tb_tl_sensor_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tl_sensor_gen_pkg.sv
// Shared encodings for the traffic-light controller and its sensor generator.
package tl_sensor_gen_pkg;

  typedef enum logic [1:0] {
    LIGHT_GREEN  = 2'b00,
    LIGHT_YELLOW = 2'b01,
    LIGHT_RED    = 2'b10,
    LIGHT_LEFT   = 2'b11
  } light_t;

  typedef enum logic [1:0] {
    LANE_EMPTY = 2'b00,
    LANE_WAIT  = 2'b01,
    LANE_START = 2'b10,
    LANE_DRAIN = 2'b11
  } lane_state_t;

  // Straight lanes move only on green; yellow and red never release traffic.
  function automatic logic straight_permit(input logic [1:0] light);
    return light == LIGHT_GREEN;
  endfunction

  // Left lanes move only on the arrow.
  function automatic logic left_permit(input logic [1:0] light);
    return light == LIGHT_LEFT;
  endfunction

endpackage

// File: rtl/tl_lane_queue.sv
// One lane of vehicles: queue counter, service FSM and sticky overflow flag.
//
// state       | meaning
// ------------+------------------------------------------------------------
// LANE_EMPTY  | no vehicles queued
// LANE_WAIT   | vehicles queued, light does not permit movement
// LANE_START  | permit seen, first driver still reacting (no departure)
// LANE_DRAIN  | one vehicle leaves per permitted cycle
module tl_lane_queue
  import tl_sensor_gen_pkg::*;
#(
  parameter int QW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arr,
  input  logic          permit,
  output logic [QW-1:0] count,
  output logic          occupied,
  output logic          ovf
);

  localparam logic [QW-1:0] CNT_MAX = '1;

  lane_state_t   state_q, state_d;
  logic [QW-1:0] count_q, count_d;
  logic          ovf_q;
  logic          dep;
  logic          arr_acc;
  logic          arr_drop;

  // Departure, accepted arrival, next count and next lane state.
  always_comb begin
    dep      = (state_q == LANE_DRAIN) && permit && (count_q != '0);
    // A full lane still accepts an arrival when a vehicle leaves the same cycle.
    arr_acc  = arr && ((count_q != CNT_MAX) || dep);
    arr_drop = arr && !arr_acc;
    count_d  = count_q;
    if (arr_acc && !dep) begin
      count_d = count_q + 1'b1;
    end else if (!arr_acc && dep) begin
      count_d = count_q - 1'b1;
    end
    state_d = state_q;
    unique case (state_q)
      LANE_EMPTY: if (arr) state_d = permit ? LANE_START : LANE_WAIT;
      LANE_WAIT:  if (permit) state_d = LANE_START;
      LANE_START: state_d = permit ? LANE_DRAIN : LANE_WAIT;
      LANE_DRAIN: begin
        if (!permit) begin
          state_d = LANE_WAIT;
        end else if (count_d == '0) begin
          state_d = LANE_EMPTY;
        end
      end
      default: state_d = LANE_EMPTY;
    endcase
  end

  // State, count and sticky overflow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LANE_EMPTY;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (arr_drop) ovf_q <= 1'b1;
    end
  end

  assign count    = count_q;
  assign occupied = (count_q != '0);
  assign ovf      = ovf_q;

endmodule

// File: rtl/tl_sensor_gen.sv
// Four-lane vehicle sensor generator feeding the traffic-light controller.
module tl_sensor_gen
  import tl_sensor_gen_pkg::*;
#(
  parameter int QW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arr_a,
  input  logic          arr_al,
  input  logic          arr_b,
  input  logic          arr_bl,
  input  logic [1:0]    La,
  input  logic [1:0]    Lb,
  output logic          Ta,
  output logic          Tal,
  output logic          Tb,
  output logic          Tbl,
  output logic [QW-1:0] q_a,
  output logic [QW-1:0] q_al,
  output logic [QW-1:0] q_b,
  output logic [QW-1:0] q_bl,
  output logic [3:0]    ovf
);

  logic permit_a, permit_al, permit_b, permit_bl;
  logic ovf_a, ovf_al, ovf_b, ovf_bl;

  assign permit_a  = straight_permit(La);
  assign permit_al = left_permit(La);
  assign permit_b  = straight_permit(Lb);
  assign permit_bl = left_permit(Lb);

  tl_lane_queue #(.QW(QW)) u_lane_a (
    .clk(clk), .reset(reset), .arr(arr_a), .permit(permit_a),
    .count(q_a), .occupied(Ta), .ovf(ovf_a)
  );

  tl_lane_queue #(.QW(QW)) u_lane_al (
    .clk(clk), .reset(reset), .arr(arr_al), .permit(permit_al),
    .count(q_al), .occupied(Tal), .ovf(ovf_al)
  );

  tl_lane_queue #(.QW(QW)) u_lane_b (
    .clk(clk), .reset(reset), .arr(arr_b), .permit(permit_b),
    .count(q_b), .occupied(Tb), .ovf(ovf_b)
  );

  tl_lane_queue #(.QW(QW)) u_lane_bl (
    .clk(clk), .reset(reset), .arr(arr_bl), .permit(permit_bl),
    .count(q_bl), .occupied(Tbl), .ovf(ovf_bl)
  );

  assign ovf = {ovf_bl, ovf_b, ovf_al, ovf_a};

endmodule

// File: tb/tb_tl_sensor_gen.sv
// Scoreboard bench for tl_sensor_gen: a service-timer reference model pushes
// expected lane counts each cycle, a monitor pops and compares after each edge.
module tb_tl_sensor_gen;
  import tl_sensor_gen_pkg::*;

  localparam int QW   = 4;
  localparam int CMAX = (1 << QW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          arr_a, arr_al, arr_b, arr_bl;
  logic [1:0]    La, Lb;
  logic          Ta, Tal, Tb, Tbl;
  logic [QW-1:0] q_a, q_al, q_b, q_bl;
  logic [3:0]    ovf;

  typedef struct packed {
    logic [4*QW-1:0] q;
    logic [3:0]      t;
    logic [3:0]      ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model, lane index 0=a 1=al 2=b 3=bl
  int   m_cnt[4];
  int   m_streak[4];   // consecutive cycles the lane has held a permit while occupied
  bit   m_ovf[4];

  tl_sensor_gen #(.QW(QW)) dut (
    .clk(clk), .reset(reset),
    .arr_a(arr_a), .arr_al(arr_al), .arr_b(arr_b), .arr_bl(arr_bl),
    .La(La), .Lb(Lb),
    .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
    .q_a(q_a), .q_al(q_al), .q_b(q_b), .q_bl(q_bl),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i]    = 0;
      m_streak[i] = 0;
      m_ovf[i]    = 1'b0;
    end
  endtask

  // One clock of stimulus: drive at the falling edge, predict the state after
  // the next rising edge and queue it for the monitor.
  task automatic cycle(input logic [3:0] arr, input logic [1:0] la, input logic [1:0] lb);
    exp_t       e;
    logic [3:0] p;
    @(negedge clk);
    arr_a  = arr[0];
    arr_al = arr[1];
    arr_b  = arr[2];
    arr_bl = arr[3];
    La     = la;
    Lb     = lb;
    p = {lb == LIGHT_LEFT, lb == LIGHT_GREEN, la == LIGHT_LEFT, la == LIGHT_GREEN};
    for (int i = 0; i < 4; i++) begin
      bit dep;
      bit acc;
      int ns;
      // A vehicle leaves only after the permit has been held for two earlier
      // occupied cycles (light seen, then driver reaction).
      dep = p[i] && (m_cnt[i] > 0) && (m_streak[i] >= 2);
      if (p[i] && (m_cnt[i] > 0 || arr[i]))
        ns = (m_cnt[i] == 0) ? 1 : m_streak[i] + 1;
      else
        ns = 0;
      acc = arr[i] && ((m_cnt[i] < CMAX) || dep);
      if (arr[i] && !acc) m_ovf[i] = 1'b1;
      m_cnt[i]    = m_cnt[i] + (acc ? 1 : 0) - (dep ? 1 : 0);
      m_streak[i] = (ns > 100) ? 100 : ns;
    end
    for (int i = 0; i < 4; i++) begin
      e.q[i*QW +: QW] = QW'(m_cnt[i]);
      e.t[i]          = (m_cnt[i] != 0);
      e.ovf[i]        = m_ovf[i];
    end
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: after each rising edge, compare the DUT against the oldest prediction.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("lane_counts", 32'({q_bl, q_b, q_al, q_a}), 32'(e.q));
      chk("sensor_T", 32'({Tbl, Tb, Tal, Ta}), 32'(e.t));
      chk("ovf_flags", 32'(ovf), 32'(e.ovf));
    end
  end

  initial begin
    logic [1:0] la_r, lb_r;
    reset  = 1'b1;
    arr_a  = 1'b0; arr_al = 1'b0; arr_b = 1'b0; arr_bl = 1'b0;
    La     = LIGHT_RED;
    Lb     = LIGHT_RED;
    model_reset();
    #12;
    chk("reset_q", 32'({q_bl, q_b, q_al, q_a}), 32'h0);
    chk("reset_T", 32'({Tbl, Tb, Tal, Ta}), 32'h0);
    chk("reset_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Three arrivals on A under red: queue builds, no departures
    repeat (3) cycle(4'b0001, LIGHT_RED, LIGHT_RED);
    settle();
    chk("a_build_q", 32'(q_a), 32'd3);
    chk("a_build_T", 32'(Ta), 32'd1);

    // Green on A: one reaction cycle then drain to empty
    repeat (6) cycle(4'b0000, LIGHT_GREEN, LIGHT_RED);
    settle();
    chk("a_drain_q", 32'(q_a), 32'd0);
    chk("a_drain_T", 32'(Ta), 32'd0);

    // Arrivals while draining hold the count; yellow stops the lane
    repeat (2) cycle(4'b0001, LIGHT_RED, LIGHT_RED);
    repeat (5) cycle(4'b0001, LIGHT_GREEN, LIGHT_RED);
    repeat (2) cycle(4'b0000, LIGHT_YELLOW, LIGHT_RED);
    settle();
    chk("a_hold_q", 32'(q_a), 32'd4);

    // Left arrow on B drains only the B-left lane
    repeat (2) cycle(4'b1100, LIGHT_RED, LIGHT_RED);
    repeat (4) cycle(4'b0000, LIGHT_RED, LIGHT_LEFT);
    settle();
    chk("bl_drain_q", 32'(q_bl), 32'd0);
    chk("b_stay_q", 32'(q_b), 32'd2);
    chk("b_stay_T", 32'(Tb), 32'd1);

    // Sixteen arrivals on A-left saturate and flag overflow
    repeat (16) cycle(4'b0010, LIGHT_RED, LIGHT_RED);
    settle();
    chk("al_sat_q", 32'(q_al), 32'(CMAX));
    chk("al_ovf", 32'(ovf), 32'b0010);
    repeat (20) cycle(4'b0000, LIGHT_LEFT, LIGHT_RED);
    settle();
    chk("al_empty_q", 32'(q_al), 32'd0);
    chk("al_ovf_sticky", 32'(ovf), 32'b0010);

    // Randomized traffic with slowly changing lights
    la_r = LIGHT_RED;
    lb_r = LIGHT_GREEN;
    repeat (400) begin
      logic [3:0] arr_r;
      if ($urandom_range(3) == 0) la_r = 2'($urandom_range(3));
      if ($urandom_range(3) == 0) lb_r = 2'($urandom_range(3));
      for (int i = 0; i < 4; i++) arr_r[i] = ($urandom_range(2) != 0);
      cycle(arr_r, la_r, lb_r);
    end

    // Build up A then assert reset between edges while it drains
    repeat (4) cycle(4'b0001, LIGHT_RED, LIGHT_RED);
    repeat (3) cycle(4'b0000, LIGHT_GREEN, LIGHT_RED);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_q", 32'({q_bl, q_b, q_al, q_a}), 32'h0);
    chk("async_reset_T", 32'({Tbl, Tb, Tal, Ta}), 32'h0);
    chk("async_reset_ovf", 32'(ovf), 32'h0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Traffic resumes normally after reset
    repeat (60) begin
      logic [3:0] arr_r;
      arr_r = 4'($urandom_range(15));
      cycle(arr_r, 2'($urandom_range(3)), 2'($urandom_range(3)));
    end

    for (int k = 0; k < 5 && exp_q.size() != 0; k++) settle();
    if (exp_q.size() != 0) chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
